reg_pipe: RTL and testbench

//   Parametrised elastic register pipeline. Generalises the single 8-bit enabled register
//   to WIDTH bits x DEPTH stages, with a valid/ready handshake and per-stage bubble collapsing.

---
 rtl/reg_pipe_if.sv | 22 ++
 rtl/reg_pipe.sv | 92 +++++++++
 tb/tb_reg_pipe.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_pipe_if.sv
// Handshake bundle for reg_pipe: producer-side in_* and consumer-side out_* signals.
// The slave modport is the pipeline's view; master is the surrounding datapath's view.
interface reg_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/reg_pipe.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready handshake and bubble collapsing.
// Optional occupancy port `count` is built when REG_PIPE_COUNT_EN is defined.
module reg_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    reg_pipe_if.slave                  p
`ifdef REG_PIPE_COUNT_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] count
`endif
);
    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [DEPTH-1:0]            go, adv;
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic                        in_xfer;

    // Ready chain runs from the output back to stage 0, so a full pipe still
    // accepts a word in the same cycle its head word leaves.
    always_comb begin
        adv            = '0;
        go             = '0;
        adv[DEPTH-1]   = vld_q[DEPTH-1] & p.out_ready;
        go[DEPTH-1]    = ~vld_q[DEPTH-1] | adv[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = vld_q[i] & go[i+1];
            go[i]  = ~vld_q[i] | adv[i];
        end
    end

    assign p.in_ready = go[0] & ~flush;
    assign in_xfer    = p.in_valid & p.in_ready;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (flush) begin
            vld_d = '0;
        end else begin
            if (go[0]) begin
                vld_d[0] = in_xfer;
                if (in_xfer) data_d[0] = p.in_data;
            end
            // Bubbles move forward as vld=0 but never overwrite a stage's data.
            for (int i = 1; i < DEPTH; i++) begin
                if (go[i]) begin
                    vld_d[i] = vld_q[i-1];
                    if (vld_q[i-1]) data_d[i] = data_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign p.out_valid = vld_q[DEPTH-1];
    assign p.out_data  = data_q[DEPTH-1];

`ifdef REG_PIPE_COUNT_EN
    localparam int CW = $clog2(DEPTH + 1);

    logic          out_xfer;
    logic [CW-1:0] count_q, count_d;

    assign out_xfer = vld_q[DEPTH-1] & p.out_ready;

    always_comb begin
        count_d = count_q;
        if (flush)                    count_d = '0;
        else if (in_xfer & ~out_xfer) count_d = count_q + CW'(1);
        else if (~in_xfer & out_xfer) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
`endif
endmodule

// File: tb/tb_reg_pipe.sv
// Self-checking bench for reg_pipe: directed scenarios plus a randomized run against
// a queue-based reference model (word visible at max(accept+DEPTH, prev_departure+1)).
module tb_reg_pipe;
    localparam int W  = 8;
    localparam int D  = 3;
    localparam int CW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    reg_pipe_if #(.WIDTH(W)) pif ();
`ifdef REG_PIPE_COUNT_EN
    logic [CW-1:0] count;
`endif

    reg_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .p     (pif)
`ifdef REG_PIPE_COUNT_EN
        ,
        .count (count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of words with their accept cycle.
    logic [W-1:0] mq_data[$];
    int           mq_acc[$];
    int           m_last_dep;
    int           m_cyc;
    logic [W-1:0] m_last_out;

    function automatic logic m_ov();
        int avail;
        if (mq_data.size() == 0) return 1'b0;
        avail = mq_acc[0] + D;
        if (m_last_dep + 1 > avail) avail = m_last_dep + 1;
        return m_cyc >= avail;
    endfunction

    function automatic logic m_ir(input logic fl, input logic ordy);
        return !fl && (mq_data.size() < D || ordy);
    endfunction

    function automatic logic [W-1:0] m_od();
        return m_ov() ? mq_data[0] : m_last_out;
    endfunction

    task automatic m_clear();
        mq_data.delete();
        mq_acc.delete();
        m_last_dep = -100;
    endtask

    task automatic m_edge(input logic r, input logic fl, input logic iv,
                          input logic [W-1:0] id, input logic ordy);
        logic ov, ir;
        ov = m_ov();
        ir = m_ir(fl, ordy);
        if (r) begin
            m_clear();
            m_last_out = '0;
        end else if (fl) begin
            if (ov) m_last_out = mq_data[0];
            m_clear();
        end else begin
            if (ov && ordy) begin
                m_last_out = mq_data.pop_front();
                void'(mq_acc.pop_front());
                m_last_dep = m_cyc;
            end
            if (iv && ir) begin
                mq_data.push_back(id);
                mq_acc.push_back(m_cyc);
            end
        end
        m_cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        pif.in_valid = 1'b0; pif.in_data = '0; pif.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", pif.out_valid); end
        checks++; if (pif.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", pif.out_data); end
        checks++; if (pif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", pif.in_ready); end
`ifdef REG_PIPE_COUNT_EN
        checks++; if (count !== CW'(0)) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_stream();
        logic [W-1:0] words [3];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        pif.out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            pif.in_valid = (k < 3);
            pif.in_data  = (k < 3) ? words[k] : 8'h00;
            #1;
            checks++; if (pif.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready k=%0d got %b exp 1", k, pif.in_ready); end
            if (k >= 3 && k < 6) begin
                checks++;
                if (pif.out_valid !== 1'b1 || pif.out_data !== words[k-3]) begin
                    errors++; $display("FAIL stream_out k=%0d got v=%b d=%h exp v=1 d=%h", k, pif.out_valid, pif.out_data, words[k-3]);
                end
            end else begin
                checks++;
                if (pif.out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle k=%0d got v=%b exp 0", k, pif.out_valid); end
            end
            step();
        end
        #1;
        checks++; if (pif.out_data !== 8'h33) begin errors++; $display("FAIL stream_hold got %h exp 33", pif.out_data); end
    endtask

    task automatic test_fill_stall();
        int   idx;
        logic acc;
        idx = 0;
        pif.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = W'(8'hA0 + idx);
            #1;
            checks++; if (pif.in_ready !== (k < 3)) begin errors++; $display("FAIL fill_in_ready k=%0d got %b exp %b", k, pif.in_ready, (k < 3)); end
            if (k >= 3) begin
                checks++;
                if (pif.out_valid !== 1'b1 || pif.out_data !== 8'hA0) begin
                    errors++; $display("FAIL fill_head k=%0d got v=%b d=%h exp v=1 d=a0", k, pif.out_valid, pif.out_data);
                end
            end
            acc = pif.in_ready;
            step();
            if (acc) idx++;
        end
        checks++; if (idx !== 3) begin errors++; $display("FAIL fill_accepted got %0d exp 3", idx); end
`ifdef REG_PIPE_COUNT_EN
        checks++; if (count !== CW'(3)) begin errors++; $display("FAIL fill_count got %0d exp 3", count); end
`endif
        // Full with consumer ready: one out, one in, same cycle.
        pif.out_ready = 1'b1;
        pif.in_valid  = 1'b1;
        pif.in_data   = 8'hA3;
        #1;
        checks++; if (pif.in_ready !== 1'b1) begin errors++; $display("FAIL full_pass_in_ready got %b exp 1", pif.in_ready); end
        checks++; if (pif.out_valid !== 1'b1 || pif.out_data !== 8'hA0) begin errors++; $display("FAIL full_pass_out got v=%b d=%h exp v=1 d=a0", pif.out_valid, pif.out_data); end
        step();
        pif.in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            checks++;
            if (pif.out_valid !== 1'b1 || pif.out_data !== W'(8'hA1 + j)) begin
                errors++; $display("FAIL drain_order j=%0d got v=%b d=%h exp v=1 d=%h", j, pif.out_valid, pif.out_data, W'(8'hA1 + j));
            end
            step();
        end
        #1;
        checks++; if (pif.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got v=%b exp 0", pif.out_valid); end
    endtask

    task automatic test_flush();
        pif.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = W'(k + 1);
            step();
        end
        flush = 1'b1;
        pif.in_valid = 1'b1;
        pif.in_data  = 8'h55;
        #1;
        checks++; if (pif.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", pif.in_ready); end
        step();
        flush = 1'b0;
        pif.in_valid  = 1'b0;
        pif.out_ready = 1'b1;
        #1;
        checks++; if (pif.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", pif.out_valid); end
        checks++; if (pif.out_data !== 8'hA3) begin errors++; $display("FAIL flush_out_data got %h exp a3", pif.out_data); end
`ifdef REG_PIPE_COUNT_EN
        checks++; if (count !== CW'(0)) begin errors++; $display("FAIL flush_count got %0d exp 0", count); end
`endif
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (pif.out_valid !== 1'b0) begin errors++; $display("FAIL flush_ghost k=%0d got v=%b d=%h exp v=0", k, pif.out_valid, pif.out_data); end
        end
    endtask

    task automatic test_reset_inflight();
        pif.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pif.in_valid = 1'b1;
            pif.in_data  = W'(8'h66 + 8'h11 * k);
            step();
        end
        pif.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        pif.out_ready = 1'b1;
        #1;
        checks++; if (pif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_fly_out_valid got %b exp 0", pif.out_valid); end
        checks++; if (pif.out_data !== 8'h00) begin errors++; $display("FAIL rst_fly_out_data got %h exp 00", pif.out_data); end
`ifdef REG_PIPE_COUNT_EN
        checks++; if (count !== CW'(0)) begin errors++; $display("FAIL rst_fly_count got %0d exp 0", count); end
`endif
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (pif.out_valid !== 1'b0) begin errors++; $display("FAIL rst_fly_ghost k=%0d got v=%b d=%h exp v=0", k, pif.out_valid, pif.out_data); end
        end
    endtask

    task automatic test_random();
        logic         r, fl, iv, ordy;
        logic [W-1:0] id;
        rst = 1'b1; flush = 1'b0; pif.in_valid = 1'b0; pif.out_ready = 1'b0;
        step();
        rst = 1'b0;
        m_clear();
        m_last_out = '0;
        m_cyc = 0;
        for (int n = 0; n < 800; n++) begin
            r    = ($urandom_range(63) == 0);
            fl   = ($urandom_range(15) == 0);
            iv   = ($urandom_range(9) < 7);
            ordy = (n % 200 < 100) ? ($urandom_range(9) < 3) : ($urandom_range(9) < 8);
            id   = W'($urandom);
            rst = r; flush = fl; pif.in_valid = iv; pif.in_data = id; pif.out_ready = ordy;
            #1;
            checks++; if (pif.in_ready !== m_ir(fl, ordy)) begin errors++; $display("FAIL rand_in_ready n=%0d got %b exp %b", n, pif.in_ready, m_ir(fl, ordy)); end
            checks++; if (pif.out_valid !== m_ov()) begin errors++; $display("FAIL rand_out_valid n=%0d got %b exp %b", n, pif.out_valid, m_ov()); end
            checks++; if (pif.out_data !== m_od()) begin errors++; $display("FAIL rand_out_data n=%0d got %h exp %h", n, pif.out_data, m_od()); end
`ifdef REG_PIPE_COUNT_EN
            checks++; if (count !== CW'(mq_data.size())) begin errors++; $display("FAIL rand_count n=%0d got %0d exp %0d", n, count, mq_data.size()); end
`endif
            @(posedge clk);
            m_edge(r, fl, iv, id, ordy);
            #1;
        end
        rst = 1'b0; flush = 1'b0; pif.in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_stall();
        test_flush();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
